serial_alu: RTL
===============

Name: serial_alu

Overview:
- Parametrised, multi-cycle successor to the single-bit ALU slice.
- Processes a WIDTH-bit operation SLICE bits per clock, least-significant slice first.
- Carry ripples through a registered carry flop between slices.
- Sits behind a valid/ready handshake, returns result plus C/Z/V/N flags, and adds an SLT mode the single-bit slice lacks.

Parameters:
WIDTH  32  operand/result width in bits; must be >=2 and a multiple of SLICE
SLICE  1   bits processed per cycle; NSLICE = WIDTH/SLICE cycles per operation

Ports:
clk        input   1      rising-edge clock
rst_n      input   1      synchronous, active-low reset
in_valid   input   1      operands/op presented
in_ready   output  1      block can accept; high only in IDLE
op         input   3      000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR
a          input   WIDTH  operand A
b          input   WIDTH  operand B
out_valid  output  1      result/flags valid; high only in DONE
out_ready  input   1      consumer accepts result
result     output  WIDTH  operation result
carry      output  1      carry flag
zero       output  1      result == 0
overflow   output  1      signed overflow flag
negative   output  1      result[WIDTH-1]

Behaviour:
- Reset:
  - Synchronous, active-low: when rst_n=0 at a rising edge, state becomes IDLE.
  - result, carry, zero, overflow, negative, out_valid and the internal carry/slice counter all become 0; in_ready=1 after that edge.
  - Reset mid-BUSY or in DONE aborts the operation; the partial or pending result is discarded and never presented.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - in_valid=1 at an edge latches a, b, op and clears the slice counter to 0.
  - Internal carry is preset to 1 for SUB/SLT (b inverted) and to 0 otherwise.
  - Goes to BUSY.
- BUSY:
  - in_ready=0; in_valid is ignored.
  - At each edge, slice k (bits [k*SLICE +: SLICE]) is computed and written into the result shift/accumulate register.
  - Arithmetic ops update the carry flop with the slice carry-out.
  - The counter increments; after slice NSLICE-1 the state goes to DONE.
- Latency: if accepted at edge E0, out_valid is visible after edge E0+NSLICE. With WIDTH=8, SLICE=2 that is 4 edges.
- DONE:
  - out_valid=1; result and flags are held stable while out_ready=0.
  - An edge with out_ready=1 goes to IDLE and drops out_valid.
  - in_ready stays 0 through DONE, so the next accept is one edge later at the earliest.
  - Throughput: one operation per NSLICE+2 cycles with no backpressure.
- Arithmetic (modulo 2^WIDTH):
  - ADD: a+b.
  - SUB: a+~b+1.
  - carry: final carry-out (SUB: 1 means no borrow).
  - overflow: carry into MSB XOR carry out of MSB.
- SLT:
  - Performs SUB internally.
  - result = {(WIDTH-1) zeros, N_sub XOR V_sub}, where N_sub is the MSB of the subtraction result.
  - carry and overflow are reported from the subtraction.
  - zero and negative are computed on the final SLT result.
- Logic ops: bitwise per slice; carry=0 and overflow=0.
- Flag timing:
  - zero and negative are computed on the final result and registered at the transition into DONE.
  - Flags are not updated during BUSY; visible flags keep their previous values until DONE.
- result is only guaranteed meaningful while out_valid=1.
- Simultaneous in_valid and out_ready in DONE: out_ready is honoured, in_valid ignored. The upstream keeps in_valid high to be accepted in IDLE.

Test Plan:
- WIDTH=8, SLICE=2: ADD a=0x7F, b=0x01 -> out_valid after 4 edges, result=0x80, C=0, Z=0, V=1, N=1.
- SUB a=0x05, b=0x05 -> result=0x00, C=1, Z=1, V=0, N=0; SUB a=0x00, b=0x01 -> 0xFF, C=0, N=1.
- SLT a=0x80, b=0x01 -> result=0x01, C=1, V=1, Z=0, N=0; SLT a=0x01, b=0x80 -> result=0x00, Z=1.
- NOR a=0xF0, b=0x0C -> 0x03, C=0, V=0; NAND a=0xFF, b=0xFF -> 0x00, Z=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid -> result/flags constant, in_ready=0, no second accept. Then out_ready=1 -> IDLE, next op accepted the following edge.
- Reset mid-op: assert rst_n=0 at the 2nd BUSY edge -> after that edge state IDLE, all outputs 0, in_ready=1. A new ADD 0x01+0x01 then yields 0x02 with C=0.
- SLICE=1, WIDTH=32: ADD 0xFFFFFFFF+0x00000001 -> result=0, C=1, Z=1, V=0, out_valid exactly 32 edges after accept.

Source files
------------

// File: rtl/serial_alu.sv
// Multi-cycle ALU: processes a WIDTH-bit operation SLICE bits per clock, LSB slice first,
// with a registered ripple carry between slices and a valid/ready handshake on both sides.
module serial_alu #(
  parameter int WIDTH = 32,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             negative
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_SLT  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_OR   = 3'b111;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r, b_r, acc_r;
  logic [2:0]       op_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;

  logic             arith_s, sub_s, bb_s, c_s, cmsb_s;
  logic [SLICE-1:0] sum_s;
  logic [WIDTH-1:0] acc_next_s, fin_s;

  // Slice datapath: ripple across the SLICE low bits of the shifting operand registers.
  always_comb begin
    arith_s = (op_r == OP_ADD) || (op_r == OP_SUB) || (op_r == OP_SLT);
    sub_s   = (op_r == OP_SUB) || (op_r == OP_SLT);
    sum_s   = {SLICE{1'b0}};
    c_s     = carry_r;
    cmsb_s  = 1'b0;
    bb_s    = 1'b0;
    for (int i = 0; i < SLICE; i++) begin
      bb_s   = sub_s ? ~b_r[i] : b_r[i];
      cmsb_s = c_s;
      case (op_r)
        OP_ADD, OP_SUB, OP_SLT: sum_s[i] = a_r[i] ^ bb_s ^ c_s;
        OP_XOR:  sum_s[i] = a_r[i] ^ b_r[i];
        OP_AND:  sum_s[i] = a_r[i] & b_r[i];
        OP_NAND: sum_s[i] = ~(a_r[i] & b_r[i]);
        OP_NOR:  sum_s[i] = ~(a_r[i] | b_r[i]);
        OP_OR:   sum_s[i] = a_r[i] | b_r[i];
        default: sum_s[i] = 1'b0;
      endcase
      c_s = (a_r[i] & bb_s) | (a_r[i] & c_s) | (bb_s & c_s);
    end
  end

  // Result assembly: new slice enters at the top; SLT collapses to the signed less-than bit.
  always_comb begin
    acc_next_s = acc_r >> SLICE;
    acc_next_s[WIDTH-1 -: SLICE] = sum_s;
    if (op_r == OP_SLT) begin
      fin_s = {{(WIDTH-1){1'b0}}, acc_next_s[WIDTH-1] ^ (cmsb_s ^ c_s)};
    end else begin
      fin_s = acc_next_s;
    end
  end

  // Control FSM with registered handshake outputs, result and flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      acc_r     <= {WIDTH{1'b0}};
      op_r      <= 3'b000;
      carry_r   <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= {WIDTH{1'b0}};
      carry     <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      negative  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            op_r     <= op;
            acc_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            carry_r  <= (op == OP_SUB) || (op == OP_SLT);
            in_ready <= 1'b0;
            state_r  <= BUSY;
          end else begin
            in_ready <= 1'b1;
          end
        end
        BUSY: begin
          acc_r   <= acc_next_s;
          a_r     <= a_r >> SLICE;
          b_r     <= b_r >> SLICE;
          carry_r <= arith_s ? c_s : carry_r;
          cnt_r   <= cnt_r + CW'(1);
          if (cnt_r == CW'(NSLICE - 1)) begin
            result    <= fin_s;
            carry     <= arith_s & c_s;
            overflow  <= arith_s & (cmsb_s ^ c_s);
            zero      <= (fin_s == {WIDTH{1'b0}});
            negative  <= fin_s[WIDTH-1];
            out_valid <= 1'b1;
            state_r   <= DONE;
          end else begin
            state_r <= BUSY;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule
